consolidate_sequencer: RTL and testbench
========================================

# consolidate_sequencer

Top-level sequencer for architectural register consolidation. It accepts a consolidation request and holds the front end stalled until the pipeline drains. It then pulses `startConsolidate` to the register-consolidation stage and waits for that stage's `doneConsolidate`. Once consolidation completes, every architectural value lives at physical register index == logical index, so the block rewrites the AMT and RMT to the identity mapping, clears the free list and refills it with physical registers SIZE_RMT..SIZE_PHYSICAL-1.

## Interface
- SIZE_RMT, 64, number of logical registers; AMT and RMT depth.
- SIZE_PHYSICAL, 96, number of physical registers; must be greater than SIZE_RMT.
- FL_WR_WIDTH, 4, free-list write lanes per cycle.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when the watchdog macro is defined.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- consolidateReq_i  in  1  level request; the requester holds it until consolidateAck_o.
- pipeDrained_i  in  1  no instructions in flight after rename.
- stallFrontEnd_o  out  1  stall for fetch/rename.
- busy_o  out  1  block is not in IDLE.
- startConsolidate_o  out  1  one-cycle start pulse to the consolidation stage.
- doneConsolidate_i  in  1  one-cycle completion pulse from the consolidation stage.
- mapWrEn_o  out  1  write enable, shared by AMT and RMT.
- mapWrAddr_o  out  log2(SIZE_RMT)  logical index to write.
- mapWrData_o  out  log2(SIZE_PHYSICAL)  physical tag; equals mapWrAddr_o zero-extended.
- flClear_o  out  1  resets the free-list head, tail and count.
- flWrEn_o  out  FL_WR_WIDTH  per-lane push enable.
- flWrData_o  out  FL_WR_WIDTH x log2(SIZE_PHYSICAL)  per-lane physical tag.
- consolidateAck_o  out  1  one-cycle completion pulse to the requester.
- timeoutErr_o  out  1  sticky watchdog error; constant 0 without the macro.

## Operation
- States and transitions:
  - IDLE: go to DRAIN when consolidateReq_i=1.
  - DRAIN: go to START when pipeDrained_i=1.
  - START: lasts one cycle; go to WAIT_DONE.
  - WAIT_DONE: go to REMAP when doneConsolidate_i=1.
  - REMAP: go to FL_CLEAR after index SIZE_RMT-1.
  - FL_CLEAR: lasts one cycle; go to FL_FILL.
  - FL_FILL: go to ACK after the last group is pushed.
  - ACK: lasts one cycle; go to IDLE.
- Outputs are decoded only from the state register and counters. No input reaches an output combinationally.
- stallFrontEnd_o and busy_o are 1 in every state except IDLE.
- startConsolidate_o is 1 only in START. consolidateAck_o is 1 only in ACK.
- REMAP: a counter runs 0..SIZE_RMT-1, one per cycle. mapWrEn_o=1, mapWrAddr_o=counter, mapWrData_o=counter.
- FL_CLEAR: flClear_o=1 for one cycle.
- FL_FILL: tag base b starts at SIZE_RMT and advances by FL_WR_WIDTH each cycle. Lane k drives tag b+k, enabled only when b+k < SIZE_PHYSICAL. The final group can be partial. FL_FILL takes ceil((SIZE_PHYSICAL-SIZE_RMT)/FL_WR_WIDTH) cycles.
- Counter widths: counters are log2(SIZE_PHYSICAL)+1 bits, so the compare at SIZE_PHYSICAL never wraps.
- Boundary rules:
  - doneConsolidate_i outside WAIT_DONE is ignored.
  - doneConsolidate_i in the same cycle as START is ignored.
  - consolidateReq_i while busy has no effect.
  - A request still high in ACK does not retrigger. IDLE resamples it on the next cycle.
  - pipeDrained_i deasserting after DRAIN is ignored.
- Reset mid-operation: all state returns to IDLE and every output goes to 0. Recovering the AMT, RMT and free list is the responsibility of the core-wide reset.

## Timing
- Every output resets to 0.
- Request accepted at cycle 0 with pipeDrained_i=1: DRAIN at cycle 1, startConsolidate_o at cycle 2, WAIT_DONE from cycle 3.
- doneConsolidate_i at cycle D:
  - REMAP occupies cycles D+1..D+SIZE_RMT.
  - FL_CLEAR is at cycle D+SIZE_RMT+1.
  - FL_FILL occupies the next F cycles.
  - consolidateAck_o is high at cycle D+SIZE_RMT+F+2.
- Map and free-list writes land at the clock edge that ends each cycle.

## Configuration
- CONSOLIDATE_TIMEOUT_EN
  - Defined: a cycle counter runs in WAIT_DONE. If it reaches TIMEOUT_CYCLES with no done pulse, timeoutErr_o sets (sticky until reset) and the FSM goes straight to ACK, skipping REMAP and the free-list steps.
  - Not defined: no counter, timeoutErr_o is tied to 0, and WAIT_DONE waits indefinitely.

## Structure
- Shared package holds:
  - the state enum typedef;
  - the width constants for logical and physical tags.
- One sub-module, consolidate_fl_filler: owns the tag base counter and produces the per-lane enables, the lane tags and its last-group flag.

## Test plan
- SIZE_RMT=64, SIZE_PHYSICAL=96, FL_WR_WIDTH=4. Request with drained=1 and done 10 cycles after start:
  - start at cycle 2;
  - 64 map writes with data equal to address (0..63);
  - one flClear_o cycle;
  - 8 fill cycles pushing tags 64..95 in order;
  - a single ack.
- SIZE_PHYSICAL=94: last fill cycle has flWrEn_o=4'b0011 with tags 92 and 93.
- pipeDrained_i held 0 for 20 cycles, then 1: start occurs exactly 1 cycle after drained rises; stall is high throughout.
- Spurious doneConsolidate_i while in DRAIN: ignored; REMAP begins only after the real done pulse.
- Reset asserted in the middle of REMAP: all outputs 0 immediately; FSM in IDLE; a new request then runs a full sequence.
- With CONSOLIDATE_TIMEOUT_EN and TIMEOUT_CYCLES=16, no done pulse: timeoutErr_o=1 and ack after 16 WAIT_DONE cycles; no map or free-list writes.

Source files
------------

// File: rtl/consolidate_sequencer_pkg.sv
// Shared types and default sizes for the register-consolidation sequencer.
// Holds the FSM state enum, the default logical/physical tag widths and the
// counter-width helper used by the top and the free-list filler.
package consolidate_sequencer_pkg;

  localparam int unsigned DEF_SIZE_RMT       = 64;
  localparam int unsigned DEF_SIZE_PHYSICAL  = 96;
  localparam int unsigned DEF_FL_WR_WIDTH    = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  // Default tag widths: logical index and physical tag.
  localparam int unsigned LOG_TAG_W  = $clog2(DEF_SIZE_RMT);
  localparam int unsigned PHYS_TAG_W = $clog2(DEF_SIZE_PHYSICAL);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DRAIN     = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_REMAP     = 3'd4,
    S_FL_CLEAR  = 3'd5,
    S_FL_FILL   = 3'd6,
    S_ACK       = 3'd7
  } state_e;

  // One extra bit so comparisons against SIZE_PHYSICAL never wrap.
  function automatic int unsigned cnt_width(input int unsigned size_physical);
    return $clog2(size_physical) + 1;
  endfunction

endpackage

// File: rtl/consolidate_sequencer_if.sv
// Request/handshake, map-write and free-list-write bundle of the
// consolidation sequencer.
//   master : the sequencer (drives stall, start, map/free-list writes, ack)
//   slave  : the surrounding core (drives request, drained, done)
interface consolidate_sequencer_if
  import consolidate_sequencer_pkg::*;
#(
  parameter int unsigned SIZE_RMT      = DEF_SIZE_RMT,
  parameter int unsigned SIZE_PHYSICAL = DEF_SIZE_PHYSICAL,
  parameter int unsigned FL_WR_WIDTH   = DEF_FL_WR_WIDTH
);

  localparam int unsigned MAP_AW = $clog2(SIZE_RMT);
  localparam int unsigned TAG_W  = $clog2(SIZE_PHYSICAL);

  logic                                   consolidateReq_i;
  logic                                   pipeDrained_i;
  logic                                   doneConsolidate_i;
  logic                                   stallFrontEnd_o;
  logic                                   busy_o;
  logic                                   startConsolidate_o;
  logic                                   mapWrEn_o;
  logic [MAP_AW-1:0]                      mapWrAddr_o;
  logic [TAG_W-1:0]                       mapWrData_o;
  logic                                   flClear_o;
  logic [FL_WR_WIDTH-1:0]                 flWrEn_o;
  logic [FL_WR_WIDTH-1:0][TAG_W-1:0]      flWrData_o;
  logic                                   consolidateAck_o;
  logic                                   timeoutErr_o;

  modport master (
    input  consolidateReq_i, pipeDrained_i, doneConsolidate_i,
    output stallFrontEnd_o, busy_o, startConsolidate_o,
           mapWrEn_o, mapWrAddr_o, mapWrData_o,
           flClear_o, flWrEn_o, flWrData_o,
           consolidateAck_o, timeoutErr_o
  );

  modport slave (
    output consolidateReq_i, pipeDrained_i, doneConsolidate_i,
    input  stallFrontEnd_o, busy_o, startConsolidate_o,
           mapWrEn_o, mapWrAddr_o, mapWrData_o,
           flClear_o, flWrEn_o, flWrData_o,
           consolidateAck_o, timeoutErr_o
  );

endinterface

// File: rtl/consolidate_fl_filler.sv
// Free-list refill generator: walks the tag base from SIZE_RMT upward by
// FL_WR_WIDTH per cycle and produces registered per-lane push enables/tags.
// Ports:
//   clk, reset     : clock, async active-high reset
//   load_i         : next cycle is the first fill group (base <= SIZE_RMT)
//   step_i         : a fill group is on the outputs this cycle (advance base)
//   active_i       : next cycle is a fill cycle (outputs enabled)
//   wr_en_o        : per-lane push enable (registered)
//   wr_data_o      : per-lane physical tag (registered, 0 when lane idle)
//   last_c         : the group currently on the outputs is the final one
module consolidate_fl_filler
  import consolidate_sequencer_pkg::*;
#(
  parameter int unsigned SIZE_RMT      = DEF_SIZE_RMT,
  parameter int unsigned SIZE_PHYSICAL = DEF_SIZE_PHYSICAL,
  parameter int unsigned FL_WR_WIDTH   = DEF_FL_WR_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           load_i,
  input  logic                                           step_i,
  input  logic                                           active_i,
  output logic [FL_WR_WIDTH-1:0]                         wr_en_o,
  output logic [FL_WR_WIDTH-1:0][$clog2(SIZE_PHYSICAL)-1:0] wr_data_o,
  output logic                                           last_c
);

  localparam int unsigned CW    = cnt_width(SIZE_PHYSICAL);
  localparam int unsigned TAG_W = $clog2(SIZE_PHYSICAL);

  logic [CW-1:0]                    base_q, base_d;
  logic [CW-1:0]                    lane_tag;
  logic [FL_WR_WIDTH-1:0]           wr_en_q, wr_en_d;
  logic [FL_WR_WIDTH-1:0][TAG_W-1:0] wr_data_q, wr_data_d;

  // Next base and the lane pattern it produces; lanes past the top tag stay off.
  always_comb begin
    base_d    = base_q;
    lane_tag  = '0;
    wr_en_d   = '0;
    wr_data_d = '0;
    if (load_i) begin
      base_d = CW'(SIZE_RMT);
    end else if (step_i) begin
      base_d = base_q + CW'(FL_WR_WIDTH);
    end
    for (int k = 0; k < int'(FL_WR_WIDTH); k++) begin
      lane_tag     = base_d + CW'(k);
      wr_en_d[k]   = active_i && (lane_tag < CW'(SIZE_PHYSICAL));
      wr_data_d[k] = wr_en_d[k] ? TAG_W'(lane_tag) : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q    <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
    end else begin
      base_q    <= base_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign last_c    = (base_q + CW'(FL_WR_WIDTH)) >= CW'(SIZE_PHYSICAL);
  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: rtl/consolidate_sequencer.sv
// Architectural register consolidation sequencer. Stalls the front end,
// waits for drain, kicks the consolidation stage, then rewrites AMT/RMT to
// the identity map and rebuilds the free list with tags SIZE_RMT..SIZE_PHYSICAL-1.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : consolidate_sequencer_if.master (request/drained/done in;
//                stall, busy, start, map writes, free-list writes, ack,
//                timeout error out; all outputs registered)
// Optional feature: CONSOLIDATE_TIMEOUT_EN adds a WAIT_DONE watchdog that
// sets a sticky timeoutErr_o and jumps to ACK after TIMEOUT_CYCLES.
module consolidate_sequencer
  import consolidate_sequencer_pkg::*;
#(
  parameter int unsigned SIZE_RMT       = DEF_SIZE_RMT,
  parameter int unsigned SIZE_PHYSICAL  = DEF_SIZE_PHYSICAL,
  parameter int unsigned FL_WR_WIDTH    = DEF_FL_WR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  consolidate_sequencer_if.master bus
);

  localparam int unsigned CW     = cnt_width(SIZE_PHYSICAL);
  localparam int unsigned MAP_AW = $clog2(SIZE_RMT);
  localparam int unsigned TAG_W  = $clog2(SIZE_PHYSICAL);

  if (SIZE_PHYSICAL <= SIZE_RMT || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("consolidate_sequencer: invalid size/timeout configuration");
  end

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic                map_en_q, map_en_d;
  logic [MAP_AW-1:0]   map_addr_q, map_addr_d;
  logic [TAG_W-1:0]    map_data_q, map_data_d;
  logic                fl_clear_q, fl_clear_d;
  logic                ack_q, ack_d;
  logic                fill_last_c;

`ifdef CONSOLIDATE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                timeout_err_q, timeout_err_d;
`endif

  // Next state, then every output decoded from the next state so it is
  // registered and aligned with the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef CONSOLIDATE_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      S_IDLE:  if (bus.consolidateReq_i) state_d = S_DRAIN;
      S_DRAIN: if (bus.pipeDrained_i)    state_d = S_START;
      S_START: begin
        state_d = S_WAIT_DONE;
`ifdef CONSOLIDATE_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT_DONE: begin
        if (bus.doneConsolidate_i) begin
          state_d = S_REMAP;
          cnt_d   = '0;
        end
`ifdef CONSOLIDATE_TIMEOUT_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = S_ACK;
          timeout_err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end
      S_REMAP: begin
        if (cnt_q == CW'(SIZE_RMT - 1)) state_d = S_FL_CLEAR;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      S_FL_CLEAR: state_d = S_FL_FILL;
      S_FL_FILL:  if (fill_last_c) state_d = S_ACK;
      S_ACK:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    start_d    = (state_d == S_START);
    map_en_d   = (state_d == S_REMAP);
    map_addr_d = map_en_d ? MAP_AW'(cnt_d) : '0;
    map_data_d = map_en_d ? TAG_W'(cnt_d) : '0;
    fl_clear_d = (state_d == S_FL_CLEAR);
    ack_d      = (state_d == S_ACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      map_en_q   <= 1'b0;
      map_addr_q <= '0;
      map_data_q <= '0;
      fl_clear_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      map_en_q   <= map_en_d;
      map_addr_q <= map_addr_d;
      map_data_q <= map_data_d;
      fl_clear_q <= fl_clear_d;
      ack_q      <= ack_d;
    end
  end

`ifdef CONSOLIDATE_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.timeoutErr_o = timeout_err_q;
`else
  assign bus.timeoutErr_o = 1'b0;
`endif

  consolidate_fl_filler #(
    .SIZE_RMT      (SIZE_RMT),
    .SIZE_PHYSICAL (SIZE_PHYSICAL),
    .FL_WR_WIDTH   (FL_WR_WIDTH)
  ) u_fl_filler (
    .clk       (clk),
    .reset     (reset),
    .load_i    (state_q == S_FL_CLEAR),
    .step_i    (state_q == S_FL_FILL),
    .active_i  (state_d == S_FL_FILL),
    .wr_en_o   (bus.flWrEn_o),
    .wr_data_o (bus.flWrData_o),
    .last_c    (fill_last_c)
  );

  assign bus.stallFrontEnd_o    = busy_q;
  assign bus.busy_o             = busy_q;
  assign bus.startConsolidate_o = start_q;
  assign bus.mapWrEn_o          = map_en_q;
  assign bus.mapWrAddr_o        = map_addr_q;
  assign bus.mapWrData_o        = map_data_q;
  assign bus.flClear_o          = fl_clear_q;
  assign bus.consolidateAck_o   = ack_q;

endmodule

// File: tb/tb_consolidate_sequencer.sv
// Bench for consolidate_sequencer: two instances (96 and 94 physical regs)
// run in lockstep from shared stimulus; a negedge monitor logs every
// output event with its cycle number, and each test compares the logs to
// timelines computed from the sequencing rules.
module tb_consolidate_sequencer;

  localparam int R   = 64;
  localparam int W   = 4;
  localparam int P_A = 96;
  localparam int P_B = 94;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0;
  logic drained = 1'b0;
  logic done = 1'b0;
  int   cyc = 0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  consolidate_sequencer_if #(.SIZE_RMT(R), .SIZE_PHYSICAL(P_A), .FL_WR_WIDTH(W)) bus_a ();
  consolidate_sequencer_if #(.SIZE_RMT(R), .SIZE_PHYSICAL(P_B), .FL_WR_WIDTH(W)) bus_b ();

  consolidate_sequencer #(.SIZE_RMT(R), .SIZE_PHYSICAL(P_A), .FL_WR_WIDTH(W), .TIMEOUT_CYCLES(TO))
    u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  consolidate_sequencer #(.SIZE_RMT(R), .SIZE_PHYSICAL(P_B), .FL_WR_WIDTH(W), .TIMEOUT_CYCLES(TO))
    u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_a.consolidateReq_i  = req;
  assign bus_a.pipeDrained_i     = drained;
  assign bus_a.doneConsolidate_i = done;
  assign bus_b.consolidateReq_i  = req;
  assign bus_b.pipeDrained_i     = drained;
  assign bus_b.doneConsolidate_i = done;

  // Event logs, index 0 = 96-entry instance, 1 = 94-entry instance.
  int start_log [2][$];
  int map_cyc   [2][$];
  int map_addr  [2][$];
  int map_data  [2][$];
  int clr_log   [2][$];
  int fill_cyc  [2][$];
  int fill_tag  [2][$];
  int fill_lane [2][$];
  int ack_log   [2][$];
  int stall_hi  [2];
  int busy_hi   [2];
  logic to_last [2];
  int win_lo = 0;
  int win_hi = -1;

  function automatic logic [51:0] outs_a();
    return {bus_a.stallFrontEnd_o, bus_a.busy_o, bus_a.startConsolidate_o, bus_a.mapWrEn_o,
            bus_a.mapWrAddr_o, bus_a.mapWrData_o, bus_a.flClear_o, bus_a.flWrEn_o,
            bus_a.flWrData_o, bus_a.consolidateAck_o, bus_a.timeoutErr_o};
  endfunction

  function automatic logic [51:0] outs_b();
    return {bus_b.stallFrontEnd_o, bus_b.busy_o, bus_b.startConsolidate_o, bus_b.mapWrEn_o,
            bus_b.mapWrAddr_o, bus_b.mapWrData_o, bus_b.flClear_o, bus_b.flWrEn_o,
            bus_b.flWrData_o, bus_b.consolidateAck_o, bus_b.timeoutErr_o};
  endfunction

  task automatic rec(input int d, input logic st, input logic me, input logic [5:0] ma,
                     input logic [6:0] md, input logic fc, input logic [3:0] fe,
                     input logic [3:0][6:0] fd, input logic ak, input logic stall,
                     input logic busy, input logic to);
    if (st) start_log[d].push_back(cyc);
    if (me) begin
      map_cyc[d].push_back(cyc);
      map_addr[d].push_back(int'(ma));
      map_data[d].push_back(int'(md));
    end
    if (fc) clr_log[d].push_back(cyc);
    for (int k = 0; k < W; k++) begin
      if (fe[k]) begin
        fill_cyc[d].push_back(cyc);
        fill_tag[d].push_back(int'(fd[k]));
        fill_lane[d].push_back(k);
      end
    end
    if (ak) ack_log[d].push_back(cyc);
    if (cyc >= win_lo && cyc <= win_hi) begin
      if (stall) stall_hi[d]++;
      if (busy)  busy_hi[d]++;
    end
    to_last[d] = to;
  endtask

  always @(negedge clk) begin
    rec(0, bus_a.startConsolidate_o, bus_a.mapWrEn_o, bus_a.mapWrAddr_o, bus_a.mapWrData_o,
        bus_a.flClear_o, bus_a.flWrEn_o, bus_a.flWrData_o, bus_a.consolidateAck_o,
        bus_a.stallFrontEnd_o, bus_a.busy_o, bus_a.timeoutErr_o);
    rec(1, bus_b.startConsolidate_o, bus_b.mapWrEn_o, bus_b.mapWrAddr_o, bus_b.mapWrData_o,
        bus_b.flClear_o, bus_b.flWrEn_o, bus_b.flWrData_o, bus_b.consolidateAck_o,
        bus_b.stallFrontEnd_o, bus_b.busy_o, bus_b.timeoutErr_o);
  end

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      start_log[d].delete(); map_cyc[d].delete(); map_addr[d].delete(); map_data[d].delete();
      clr_log[d].delete(); fill_cyc[d].delete(); fill_tag[d].delete(); fill_lane[d].delete();
      ack_log[d].delete(); stall_hi[d] = 0; busy_hi[d] = 0;
    end
  endtask

  // Drives one request. dw = cycles drained stays low after entering DRAIN,
  // dn = cycles from start to done (<0: never), spur adds ignored done pulses
  // in IDLE, DRAIN and the START cycle, abort_off >= 0 raises reset at that
  // cycle offset and returns immediately. Returns the expected timeline.
  task automatic drive_seq(input int dw, input int dn, input bit spur, input int abort_off,
                           output int c0, output int start_c, output int d_c, output int ack_c);
    int f;
    int horizon;
    clear_logs();
    @(posedge clk); #1;
    c0      = cyc;
    req     = 1'b1;
    drained = (dw == 0);
    done    = spur;
    start_c = c0 + 2 + dw;
    f       = (P_A - R + W - 1) / W;
    if (dn < 0) begin
      d_c = -1;
`ifdef CONSOLIDATE_TIMEOUT_EN
      ack_c = start_c + TO + 1;
`else
      ack_c = start_c + 40;
`endif
    end else begin
      d_c   = start_c + dn;
      ack_c = d_c + R + f + 2;
    end
    win_lo  = c0 + 1;
    win_hi  = ack_c + 2;
    horizon = ack_c + 3;
    while (cyc < horizon) begin
      @(posedge clk); #1;
      if (abort_off >= 0 && cyc == c0 + abort_off) begin
        req = 1'b0; drained = 1'b0; done = 1'b0; reset = 1'b1;
        return;
      end
      drained = (cyc >= c0 + 1 + dw);
      done    = (d_c >= 0 && cyc == d_c) || (spur && (cyc == c0 + 1 || cyc == start_c));
      req     = (cyc <= ack_c);
    end
    req = 1'b0; drained = 1'b0; done = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (outs_a() !== '0) begin
      miscompares++; $display("FAIL reset_outs_a: got %h want 0", outs_a());
    end
    vectors++;
    if (outs_b() !== '0) begin
      miscompares++; $display("FAIL reset_outs_b: got %h want 0", outs_b());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus_a.busy_o, bus_b.busy_o, bus_a.stallFrontEnd_o} !== 3'b000) begin
      miscompares++; $display("FAIL idle_after_reset: busy/stall got %b want 000",
                              {bus_a.busy_o, bus_b.busy_o, bus_a.stallFrontEnd_o});
    end
  endtask

  // Full timeline comparison; first run is the fixed dw=0, done 10 after start.
  task automatic test_random_sequences();
    int c0, st, dc, ak, dw, dn, p, f, n, bad, akd;
    bit spur;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        dw = 0; dn = 10; spur = 1'b0;
      end else begin
        dw = int'($urandom_range(0, 6)); dn = int'($urandom_range(1, 12));
        spur = 1'($urandom_range(0, 1));
      end
      drive_seq(dw, dn, spur, -1, c0, st, dc, ak);
      for (int d = 0; d < 2; d++) begin
        p   = (d == 0) ? P_A : P_B;
        f   = (p - R + W - 1) / W;
        n   = p - R;
        akd = dc + R + f + 2;

        vectors++;
        if (start_log[d].size() != 1 || start_log[d][0] != st) begin
          miscompares++;
          $display("FAIL start dut%0d run%0d: got %0d pulses first@%0d want 1 @%0d", d, it,
                   start_log[d].size(), (start_log[d].size() > 0) ? start_log[d][0] : -1, st);
        end

        bad = -1;
        if (map_cyc[d].size() != R) bad = R;
        else for (int i = 0; i < R; i++)
          if (bad < 0 && (map_cyc[d][i] != dc + 1 + i || map_addr[d][i] != i || map_data[d][i] != i))
            bad = i;
        vectors++;
        if (bad >= 0) begin
          miscompares++;
          $display("FAIL map_writes dut%0d run%0d: %0d writes, first bad entry %0d, want %0d writes addr=data=i at cycle %0d+i",
                   d, it, map_cyc[d].size(), bad, R, dc + 1);
        end

        vectors++;
        if (clr_log[d].size() != 1 || clr_log[d][0] != dc + R + 1) begin
          miscompares++;
          $display("FAIL fl_clear dut%0d run%0d: got %0d pulses first@%0d want 1 @%0d", d, it,
                   clr_log[d].size(), (clr_log[d].size() > 0) ? clr_log[d][0] : -1, dc + R + 1);
        end

        bad = -1;
        if (fill_tag[d].size() != n) bad = n;
        else for (int j = 0; j < n; j++)
          if (bad < 0 && (fill_tag[d][j] != R + j || fill_lane[d][j] != j % W ||
                          fill_cyc[d][j] != dc + R + 2 + j / W))
            bad = j;
        vectors++;
        if (bad >= 0) begin
          miscompares++;
          $display("FAIL fl_fill dut%0d run%0d: %0d pushes, first bad %0d, want %0d tags %0d.. from cycle %0d",
                   d, it, fill_tag[d].size(), bad, n, R, dc + R + 2);
        end

        vectors++;
        if (ack_log[d].size() != 1 || ack_log[d][0] != akd) begin
          miscompares++;
          $display("FAIL ack dut%0d run%0d: got %0d pulses first@%0d want 1 @%0d", d, it,
                   ack_log[d].size(), (ack_log[d].size() > 0) ? ack_log[d][0] : -1, akd);
        end

        vectors++;
        if (busy_hi[d] != akd - c0 || stall_hi[d] != akd - c0 || to_last[d] !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_stall dut%0d run%0d: busy %0d stall %0d to %b want %0d %0d 0",
                   d, it, busy_hi[d], stall_hi[d], to_last[d], akd - c0, akd - c0);
        end
      end
    end
  endtask

  task automatic test_drain_wait();
    int c0, st, dc, ak;
    drive_seq(20, 5, 1'b0, -1, c0, st, dc, ak);
    vectors++;
    if (start_log[0].size() != 1 || start_log[0][0] != c0 + 22) begin
      miscompares++;
      $display("FAIL drain_start: got %0d pulses first@%0d want 1 @%0d", start_log[0].size(),
               (start_log[0].size() > 0) ? start_log[0][0] : -1, c0 + 22);
    end
    vectors++;
    if (stall_hi[0] != ak - c0 || stall_hi[1] != ak - c0) begin
      miscompares++;
      $display("FAIL drain_stall: stall-high cycles %0d/%0d want %0d", stall_hi[0], stall_hi[1], ak - c0);
    end
    vectors++;
    if (ack_log[0].size() != 1 || ack_log[0][0] != ak) begin
      miscompares++;
      $display("FAIL drain_ack: got %0d pulses first@%0d want @%0d", ack_log[0].size(),
               (ack_log[0].size() > 0) ? ack_log[0][0] : -1, ak);
    end
  endtask

  task automatic test_spurious_done();
    int c0, st, dc, ak;
    drive_seq(6, 7, 1'b1, -1, c0, st, dc, ak);
    vectors++;
    if (map_cyc[0].size() != R || map_cyc[0][0] != dc + 1) begin
      miscompares++;
      $display("FAIL spurious_remap: %0d writes first@%0d want %0d @%0d", map_cyc[0].size(),
               (map_cyc[0].size() > 0) ? map_cyc[0][0] : -1, R, dc + 1);
    end
    vectors++;
    if (ack_log[1].size() != 1 || ack_log[1][0] != ak) begin
      miscompares++;
      $display("FAIL spurious_ack: got %0d pulses first@%0d want @%0d", ack_log[1].size(),
               (ack_log[1].size() > 0) ? ack_log[1][0] : -1, ak);
    end
  endtask

  task automatic test_reset_mid_remap();
    int c0, st, dc, ak;
    drive_seq(0, 3, 1'b0, 2 + 3 + 1 + 20, c0, st, dc, ak);
    #1;
    vectors++;
    if (map_cyc[0].size() != 20) begin
      miscompares++; $display("FAIL pre_reset_remap: got %0d writes want 20", map_cyc[0].size());
    end
    vectors++;
    if (outs_a() !== '0 || outs_b() !== '0) begin
      miscompares++; $display("FAIL mid_reset_outs: got %h / %h want 0", outs_a(), outs_b());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus_a.busy_o, bus_b.busy_o} !== 2'b00) begin
      miscompares++; $display("FAIL post_reset_idle: busy got %b want 00", {bus_a.busy_o, bus_b.busy_o});
    end
    drive_seq(0, 4, 1'b0, -1, c0, st, dc, ak);
    vectors++;
    if (map_cyc[0].size() != R || clr_log[0].size() != 1 || fill_tag[0].size() != P_A - R ||
        ack_log[0].size() != 1 || ack_log[0][0] != ak) begin
      miscompares++;
      $display("FAIL rerun_after_reset: map %0d clr %0d fill %0d ack %0d want %0d 1 %0d 1 @%0d",
               map_cyc[0].size(), clr_log[0].size(), fill_tag[0].size(), ack_log[0].size(),
               R, P_A - R, ak);
    end
  endtask

  task automatic test_timeout();
    int c0, st, dc, ak;
    drive_seq(0, -1, 1'b0, -1, c0, st, dc, ak);
`ifdef CONSOLIDATE_TIMEOUT_EN
    vectors++;
    if (ack_log[0].size() != 1 || ack_log[0][0] != st + TO + 1 || to_last[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_ack: %0d acks first@%0d err %b want 1 @%0d err 1", ack_log[0].size(),
               (ack_log[0].size() > 0) ? ack_log[0][0] : -1, to_last[0], st + TO + 1);
    end
    vectors++;
    if (map_cyc[0].size() != 0 || clr_log[0].size() != 0 || fill_tag[0].size() != 0) begin
      miscompares++;
      $display("FAIL timeout_no_writes: map %0d clr %0d fill %0d want 0 0 0",
               map_cyc[0].size(), clr_log[0].size(), fill_tag[0].size());
    end
`else
    vectors++;
    if (ack_log[0].size() != 0 || busy_hi[0] != win_hi - c0 || to_last[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_forever: acks %0d busy %0d err %b want 0 %0d 0", ack_log[0].size(),
               busy_hi[0], to_last[0], win_hi - c0);
    end
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus_a.timeoutErr_o !== 1'b0 || bus_a.busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_cleared: err %b busy %b want 0 0", bus_a.timeoutErr_o, bus_a.busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_random_sequences();
    test_drain_wait();
    test_spurious_done();
    test_reset_mid_remap();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
